seq_muldiv: RTL and testbench

// Shared-datapath sequential multiply/divide unit; successor to the fixed unsigned mul+div pair.
// One iterative engine runs MUL or DIV per request: 1 bit/cycle, signed or unsigned.

---
 rtl/seq_muldiv_pkg.sv | 26 ++
 rtl/seq_negate.sv | 12 +
 rtl/seq_muldiv.sv | 236 +++++++++++++++++++++++
 tb/tb_seq_muldiv.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_muldiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package seq_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'd0,
    OP_MULS = 2'd1,
    OP_DIVU = 2'd2,
    OP_DIVS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(op_e op);
    return (op == OP_DIVU) || (op == OP_DIVS);
  endfunction

  function automatic logic is_signed(op_e op);
    return (op == OP_MULS) || (op == OP_DIVS);
  endfunction

endpackage

// File: rtl/seq_negate.sv
// Conditional two's complement: y = neg ? -x : x.
module seq_negate #(
  parameter int unsigned W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  assign y_c = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_muldiv.sv
// Iterative 1-bit/cycle multiply/divide engine, signed or unsigned, with
// valid/ready request/response handshakes, flush and div-by-zero/overflow flags.
module seq_muldiv
  import seq_muldiv_pkg::*;
#(
  parameter int unsigned WidthA = 32,
  parameter int unsigned WidthB = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               op_i,
  input  logic [WidthA-1:0]        a_i,
  input  logic [WidthB-1:0]        b_i,
  input  logic                     flush_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WidthA+WidthB-1:0] prod_o,
  output logic [WidthA-1:0]        quot_o,
  output logic [WidthB-1:0]        rem_o,
  output logic                     dz_o,
  output logic                     ovf_o
);

  localparam int unsigned WidthC = WidthA + WidthB;
  localparam int unsigned CntW   = $clog2(WidthA + 1);

  if (WidthB > WidthA) begin : g_bad_width
    $error("seq_muldiv: WidthB must not exceed WidthA");
  end

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WidthC-1:0]  acc_q, acc_d;
  logic [WidthA-1:0]  opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_p_q, dz_p_d;
  logic               ovf_p_q, ovf_p_d;

  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WidthC-1:0]  prod_q, prod_d;
  logic [WidthA-1:0]  quot_q, quot_d;
  logic [WidthB-1:0]  rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  op_e                op_c;
  logic               sgn_c, a_neg_c, b_neg_c;
  logic               b_zero_c, ovf_case_c, special_c;
  logic               accept_c, rsp_hs_c;
  logic [WidthA-1:0]  abs_a_c, quot_fix_c;
  logic [WidthB-1:0]  abs_b_c, rem_fix_c;
  logic [WidthC-1:0]  prod_fix_c, mul_next_c, div_next_c;
  logic [WidthA:0]    mul_sum_c;
  logic [WidthB:0]    div_shift_c, div_diff_c;

  assign op_c       = op_e'(op_i);
  assign sgn_c      = is_signed(op_c);
  assign a_neg_c    = sgn_c & a_i[WidthA-1];
  assign b_neg_c    = sgn_c & b_i[WidthB-1];
  assign b_zero_c   = (b_i == '0);
  assign ovf_case_c = (op_c == OP_DIVS) && (a_i == {1'b1, {(WidthA-1){1'b0}}})
                      && (b_i == {WidthB{1'b1}});
  assign special_c  = is_div(op_c) & (b_zero_c | ovf_case_c);
  assign accept_c   = req_valid_i & req_ready_q & ~flush_i;
  assign rsp_hs_c   = rsp_valid_q & rsp_ready_i;

  seq_negate #(.W(WidthA)) u_abs_a    (.neg(a_neg_c), .x(a_i),                 .y_c(abs_a_c));
  seq_negate #(.W(WidthB)) u_abs_b    (.neg(b_neg_c), .x(b_i),                 .y_c(abs_b_c));
  seq_negate #(.W(WidthC)) u_fix_prod (.neg(neg_p_q), .x(acc_q),               .y_c(prod_fix_c));
  seq_negate #(.W(WidthA)) u_fix_quot (.neg(neg_p_q), .x(acc_q[WidthA-1:0]),   .y_c(quot_fix_c));
  seq_negate #(.W(WidthB)) u_fix_rem  (.neg(neg_r_q), .x(acc_q[WidthC-1:WidthA]), .y_c(rem_fix_c));

  // Shift-add step: acc = {partial product, multiplier}, multiplicand in opnd_q.
  assign mul_sum_c  = {1'b0, acc_q[WidthC-1:WidthB]} + {1'b0, opnd_q};
  assign mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[WidthB-1:1]}
                               : {1'b0, acc_q[WidthC-1:1]};

  // Restoring step: acc = {partial remainder, quotient}, divisor in opnd_q.
  assign div_shift_c = acc_q[WidthC-1:WidthA-1];
  assign div_diff_c  = div_shift_c - {1'b0, opnd_q[WidthB-1:0]};
  assign div_next_c  = div_diff_c[WidthB]
                     ? {div_shift_c[WidthB-1:0], acc_q[WidthA-2:0], 1'b0}
                     : {div_diff_c[WidthB-1:0],  acc_q[WidthA-2:0], 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = special_c ? FIX : CALC;
      CALC:    if (flush_i) state_d = IDLE;
               else if (cnt_q == '0) state_d = FIX;
      FIX:     if (flush_i) state_d = IDLE;
               else if (cnt_q == '0) state_d = DONE;
      DONE:    if (flush_i || rsp_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_out
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    neg_p_d     = neg_p_q;
    neg_r_d     = neg_r_q;
    dz_p_d      = dz_p_q;
    ovf_p_d     = ovf_p_q;
    rsp_valid_d = rsp_valid_q;
    prod_d      = prod_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    req_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          div_d = is_div(op_c);
          if (special_c) begin
            // Final result is preloaded; two FIX cycles keep the latency at 2.
            cnt_d   = CntW'(1);
            neg_p_d = 1'b0;
            neg_r_d = 1'b0;
            dz_p_d  = b_zero_c;
            ovf_p_d = ~b_zero_c;
            opnd_d  = '0;
            acc_d   = b_zero_c ? {a_i[WidthB-1:0], {WidthA{1'b1}}}
                               : {{WidthB{1'b0}}, a_i};
          end else begin
            neg_p_d = a_neg_c ^ b_neg_c;
            neg_r_d = a_neg_c;
            dz_p_d  = 1'b0;
            ovf_p_d = 1'b0;
            if (is_div(op_c)) begin
              cnt_d  = CntW'(WidthA - 1);
              opnd_d = WidthA'(abs_b_c);
              acc_d  = {{WidthB{1'b0}}, abs_a_c};
            end else begin
              cnt_d  = CntW'(WidthB - 1);
              opnd_d = abs_a_c;
              acc_d  = {{WidthA{1'b0}}, abs_b_c};
            end
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          cnt_d = '0;
        end else begin
          acc_d = div_q ? div_next_c : mul_next_c;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          prod_d      = div_q ? '0 : prod_fix_c;
          quot_d      = div_q ? quot_fix_c : '0;
          rem_d       = div_q ? rem_fix_c : '0;
          dz_d        = dz_p_q;
          ovf_d       = ovf_p_q;
        end
      end
      DONE: begin
        if (flush_i || rsp_hs_c) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b0;
          prod_d      = '0;
          quot_d      = '0;
          rem_d       = '0;
          dz_d        = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
    if (!rst_ni) begin
      acc_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      neg_p_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_p_q      <= 1'b0;
      ovf_p_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      prod_q      <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      neg_p_q     <= neg_p_d;
      neg_r_q     <= neg_r_d;
      dz_p_q      <= dz_p_d;
      ovf_p_q     <= ovf_p_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      prod_q      <= prod_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign prod_o      = prod_q;
  assign quot_o      = quot_q;
  assign rem_o       = rem_q;
  assign dz_o        = dz_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv: 8/8 instance plus a 32/32 smoke instance.
module tb_seq_muldiv;

  logic        clk;
  logic        rst_ni;
  logic        req_valid, req_ready, flush, rsp_valid, rsp_ready, dz, ovf;
  logic [1:0]  op;
  logic [7:0]  a, b, quot, rem;
  logic [15:0] prod;

  logic        req_valid32, req_ready32, flush32, rsp_valid32, rsp_ready32, dz32, ovf32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, quot32, rem32;
  logic [63:0] prod32;

  int n_tests = 0;
  int n_fail  = 0;

  seq_muldiv #(.WidthA(8), .WidthB(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .b_i(b), .flush_i(flush), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .prod_o(prod), .quot_o(quot), .rem_o(rem),
    .dz_o(dz), .ovf_o(ovf)
  );

  seq_muldiv #(.WidthA(32), .WidthB(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid32), .req_ready_o(req_ready32),
    .op_i(op32), .a_i(a32), .b_i(b32), .flush_i(flush32), .rsp_valid_o(rsp_valid32),
    .rsp_ready_i(rsp_ready32), .prod_o(prod32), .quot_o(quot32), .rem_o(rem32),
    .dz_o(dz32), .ovf_o(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accepting edge, then scramble the operands.
  task automatic start_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    chk("ready_before_req", 64'(req_ready), 64'd1);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; op = ~o; a = ~x; b = y ^ 8'h5A;
  endtask

  task automatic wait_rsp(output int edges, output logic ready_seen);
    edges = 0;
    ready_seen = 1'b0;
    while (rsp_valid !== 1'b1 && edges < 100) begin
      ready_seen = ready_seen | req_ready;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic consume_rsp(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_post_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_post_ready"}, 64'(req_ready), 64'd1);
    chk({name, "_post_zero"}, 64'({prod, quot, rem, dz, ovf}), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat, input logic [15:0] ep,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input logic eovf, input bit consume);
    int   lat;
    logic rseen;
    start_op(o, x, y);
    wait_rsp(lat, rseen);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_ready_low"}, 64'(rseen), 64'd0);
    chk({name, "_prod"}, 64'(prod), 64'(ep));
    chk({name, "_quot"}, 64'(quot), 64'(eq));
    chk({name, "_rem"}, 64'(rem), 64'(er));
    chk({name, "_flags"}, 64'({dz, ovf}), 64'({edz, eovf}));
    if (consume) consume_rsp(name);
  endtask

  task automatic run32(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int exp_lat, input logic [63:0] ep,
                       input logic [31:0] eq, input logic [31:0] er);
    int lat;
    lat = 0;
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; req_valid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid32 = 1'b0; a32 = ~x;
    while (rsp_valid32 !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_prod"}, prod32, ep);
    chk({name, "_quot"}, 64'(quot32), 64'(eq));
    chk({name, "_rem"}, 64'(rem32), 64'(er));
    @(posedge clk);
    @(negedge clk);
    chk({name, "_post_valid"}, 64'(rsp_valid32), 64'd0);
  endtask

  initial begin
    int   cnt;
    logic seen;
    rst_ni = 1'b0; req_valid = 1'b0; op = 2'd0; a = '0; b = '0; flush = 1'b0; rsp_ready = 1'b0;
    req_valid32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0; flush32 = 1'b0; rsp_ready32 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_data", 64'({prod, quot, rem, dz, ovf}), 64'd0);
    rst_ni = 1'b1;

    // Multiply, unsigned and signed
    run_op("mulu_ff_ff", 2'd0, 8'hFF, 8'hFF, 9, 16'hFE01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("muls_m3_5",  2'd1, 8'hFD, 8'h05, 9, 16'hFFF1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("muls_80_80", 2'd1, 8'h80, 8'h80, 9, 16'h4000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Divide, signed and unsigned
    run_op("divs_m7_2",  2'd3, 8'hF9, 8'h02, 9, 16'h0000, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b1);
    run_op("divu_f9_2",  2'd2, 8'hF9, 8'h02, 9, 16'h0000, 8'h7C, 8'h01, 1'b0, 1'b0, 1'b1);

    // Special cases bypass the iteration
    run_op("divu_dz",    2'd2, 8'h64, 8'h00, 2, 16'h0000, 8'hFF, 8'h64, 1'b1, 1'b0, 1'b1);
    run_op("divs_ovf",   2'd3, 8'h80, 8'hFF, 2, 16'h0000, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold DONE with a competing request pending
    run_op("hold_mulu",  2'd0, 8'h0C, 8'h0D, 9, 16'h009C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; op = 2'd0; a = 8'h03; b = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_prod", 64'(prod), 64'h009C);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    consume_rsp("hold_release");

    // Flush three cycles into CALC
    start_op(2'd0, 8'h11, 8'h22);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(req_ready), 64'd1);
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    seen = 1'b0;
    for (cnt = 0; cnt < 12; cnt++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("flush_no_rsp", 64'(seen), 64'd0);

    // Flush in IDLE blocks an accept
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op = 2'd0; a = 8'h02; b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_no_accept", 64'(req_ready), 64'd1);

    // Asynchronous reset in the middle of CALC
    start_op(2'd2, 8'h64, 8'h07);
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_data", 64'({prod, quot, rem, dz, ovf}), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    run_op("after_rst_divu", 2'd2, 8'h64, 8'h07, 9, 16'h0000, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1);

    // 32/32 smoke
    run32("w32_divu", 2'd2, 32'd1000000, 32'd7, 33, 64'd0, 32'h00022E09, 32'd1);
    run32("w32_muls", 2'd1, 32'hFFFFFFFF, 32'd7, 33, 64'hFFFFFFFF_FFFFFFF9, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
